uart_rx: RTL and testbench

- UART receiver, the downstream stage of the 8N1 transmitter (uart_tx line → uart_rx).
- Recovers 8N1 frames (1 start bit 0, 8 data bits LSB first, 1 stop bit 1) from the asynchronous serial line.
- Presents each received byte on a one-entry ready/valid output register to on-chip consumers (loopback logic, FIFO, command decoder).
- Flags framing errors and overruns.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Recovers frames (start 0, 8 data bits LSB first, stop 1)
// from an asynchronous serial line and presents each byte in a one-entry
// ready/valid output register. Framing errors and overruns are reported as
// single-cycle pulses.
//
// Ports:
//   sysclk          in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   serial_in       in   asynchronous UART line, idle high
//   data_out        out  [7:0] received byte, stable while data_out_valid=1
//   data_out_valid  out  byte held in output register
//   data_out_ready  in   consumer accepts byte on valid&ready at a rising edge
//   framing_error   out  one-cycle pulse: stop bit sampled 0
//   overrun         out  one-cycle pulse: byte completed while register full
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_LENGTH_IN_CYCLES = 125000000 / 115200,
    parameter int SAMPLE_POINT          = BAUD_LENGTH_IN_CYCLES / 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int                CNT_W      = $clog2(BAUD_LENGTH_IN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BAUD_LENGTH_IN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchronizer and edge-detect history.
    logic sync1_q;
    logic rx_s_q;
    logic rx_prev_q;

    state_t           state_q,         state_d;
    logic [CNT_W-1:0] bit_cnt_q,       bit_cnt_d;
    logic [2:0]       bit_idx_q,       bit_idx_d;
    logic [7:0]       shift_q,         shift_d;
    logic [7:0]       data_out_q,      data_out_d;
    logic             valid_q,         valid_d;
    logic             framing_error_q, framing_error_d;
    logic             overrun_q,       overrun_d;

    logic             cnt_last;

    assign cnt_last = (bit_cnt_q == CNT_LAST);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = cnt_last ? '0 : bit_cnt_q + CNT_W'(1);
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        data_out_d      = data_out_q;
        valid_d         = valid_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;

        // Pop; a commit below in the same cycle overrides it.
        if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                // Only a 1->0 transition starts a frame, so a line stuck low
                // (break) cannot retrigger.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (bit_cnt_q == CNT_SAMPLE) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = IDLE;    // glitch, silently dropped
                    end
                end
            end

            DATA: begin
                // Counter was zeroed at mid start bit, so wrapping lands on
                // mid-bit of each following data bit.
                if (cnt_last) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        // Commit allowed when empty or popped this same cycle.
                        if (!valid_q || data_out_ready) begin
                            data_out_d = shift_q;
                            valid_d    = 1'b1;
                        end else begin
                            overrun_d  = 1'b1;
                        end
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_q         <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_prev_q       <= 1'b1;
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_out_q      <= '0;
            valid_q         <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            sync1_q         <= serial_in;
            rx_s_q          <= sync1_q;
            rx_prev_q       <= rx_s_q;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            valid_q         <= valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign framing_error  = framing_error_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. A fast instance (8 cycles/bit) takes the
// directed frames; its accepted bytes are compared against a queue of expected
// bytes by a monitor that also counts error pulses. A second instance at the
// production baud divisor receives one frame from a behavioural transmitter.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BAUD    = 8;
    localparam int BAUD_LB = 1085;

    logic       sysclk         = 1'b0;
    logic       rst            = 1'b1;
    logic       serial_in      = 1'b1;
    logic       data_out_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;

    logic       serial_lb      = 1'b1;
    logic       ready_lb       = 1'b0;
    logic [7:0] data_lb;
    logic       valid_lb;
    logic       fe_lb;
    logic       ov_lb;

    always #5 sysclk = ~sysclk;

    uart_rx #(
        .BAUD_LENGTH_IN_CYCLES(BAUD),
        .SAMPLE_POINT(BAUD / 2)
    ) dut (
        .sysclk(sysclk),
        .rst(rst),
        .serial_in(serial_in),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error(framing_error),
        .overrun(overrun)
    );

    uart_rx #(
        .BAUD_LENGTH_IN_CYCLES(BAUD_LB),
        .SAMPLE_POINT(BAUD_LB / 2)
    ) dut_lb (
        .sysclk(sysclk),
        .rst(rst),
        .serial_in(serial_lb),
        .data_out(data_lb),
        .data_out_valid(valid_lb),
        .data_out_ready(ready_lb),
        .framing_error(fe_lb),
        .overrun(ov_lb)
    );

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         start_cyc = 0;
    int         rise_cyc  = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         vld_cnt   = 0;
    int         fe_lb_cnt = 0;
    int         ov_lb_cnt = 0;
    logic       vld_prev  = 1'b0;
    logic [7:0] exp_q[$];

    // Snapshots taken at the start of each scenario.
    int fe0, ov0, vld0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from updates.
    always @(negedge sysclk) begin
        if (!rst) begin
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (data_out_valid) vld_cnt++;
            if (data_out_valid && !vld_prev) rise_cyc = cyc;
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got byte 0x%0h expected none", data_out);
                end else begin
                    check("sb_byte", data_out, exp_q.pop_front());
                end
            end
            if (fe_lb) fe_lb_cnt++;
            if (ov_lb) ov_lb_cnt++;
        end
        vld_prev = data_out_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic snap();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        vld0 = vld_cnt;
    endtask

    // Drives one 8N1 frame. With rst_mid set, a one-cycle reset is applied
    // in the middle of data bit 4 and the line then returns to idle.
    task automatic send_frame(input int baud, input logic [7:0] data,
                              input logic stop_bit, input bit lb, input bit rst_mid);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (lb) serial_lb = bits[i];
            else    serial_in = bits[i];
            if (i == 0) start_cyc = cyc;
            if (rst_mid && i == 5) begin
                tick(baud / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                check("rst_data_out", data_out, 8'h00);
                check("rst_valid", data_out_valid, 1'b0);
                check("rst_framing_error", framing_error, 1'b0);
                check("rst_overrun", overrun, 1'b0);
                serial_in = 1'b1;
                return;
            end
            tick(baud);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // Reset state
        tick(3);
        check("reset_valid", data_out_valid, 1'b0);
        check("reset_data", data_out, 8'h00);
        check("reset_fe", framing_error, 1'b0);
        check("reset_ov", overrun, 1'b0);
        rst = 1'b0;
        tick(2 * BAUD);

        // Single frame 0x41, consumer always ready
        snap();
        exp_q.push_back(8'h41);
        send_frame(BAUD, 8'h41, 1'b1, 1'b0, 1'b0);
        tick(3 * BAUD);
        check_range("t1_latency", rise_cyc - start_cyc, 76, 84);
        check("t1_valid_cycles", vld_cnt - vld0, 1);
        check("t1_fe", fe_cnt - fe0, 0);
        check("t1_ov", ov_cnt - ov0, 0);
        check("t1_pending", exp_q.size(), 0);

        // Back-to-back frames with consumer stalled: first byte held
        snap();
        data_out_ready = 1'b0;
        exp_q.push_back(8'h00);
        send_frame(BAUD, 8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(BAUD, 8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(BAUD, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick(3 * BAUD);
        check("t2_ov", ov_cnt - ov0, 2);
        check("t2_fe", fe_cnt - fe0, 0);
        check("t2_valid_held", data_out_valid, 1'b1);
        check("t2_pending", exp_q.size(), 1);
        data_out_ready = 1'b1;
        tick(1);
        check("t2_valid_after_pop", data_out_valid, 1'b0);
        check("t2_data_kept", data_out, 8'h00);
        check("t2_popped", exp_q.size(), 0);

        // Short glitch is rejected, then a clean frame
        snap();
        serial_in = 1'b0;
        tick(2);
        serial_in = 1'b1;
        tick(3 * BAUD);
        check("t3_glitch_valid", vld_cnt - vld0, 0);
        check("t3_glitch_fe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h3C);
        send_frame(BAUD, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick(3 * BAUD);
        check("t3_pending", exp_q.size(), 0);

        // Bad stop bit followed by a held-low break: one framing error only
        snap();
        send_frame(BAUD, 8'h55, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b0;
        tick(30);
        serial_in = 1'b1;
        tick(3 * BAUD);
        check("t4_fe_pulses", fe_cnt - fe0, 1);
        check("t4_valid", vld_cnt - vld0, 0);
        check("t4_ov", ov_cnt - ov0, 0);
        exp_q.push_back(8'h12);
        send_frame(BAUD, 8'h12, 1'b1, 1'b0, 1'b0);
        tick(3 * BAUD);
        check("t4_pending", exp_q.size(), 0);

        // Reset in the middle of a frame discards it
        snap();
        send_frame(BAUD, 8'h77, 1'b1, 1'b0, 1'b1);
        tick(12 * BAUD);
        check("t5_valid", vld_cnt - vld0, 0);
        check("t5_fe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h77);
        send_frame(BAUD, 8'h77, 1'b1, 1'b0, 1'b0);
        tick(3 * BAUD);
        check("t5_pending", exp_q.size(), 0);

        // Production divisor, 'A' from the behavioural transmitter
        send_frame(BAUD_LB, 8'h41, 1'b1, 1'b1, 1'b0);
        w = 0;
        while (!valid_lb && w < 2000) begin
            tick(1);
            w++;
        end
        check("t6_valid", valid_lb, 1'b1);
        check("t6_data", data_lb, 8'h41);
        check("t6_fe", fe_lb_cnt, 0);
        check("t6_ov", ov_lb_cnt, 0);

        check("final_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
